// File: rtl/turf_udp_port_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | turf_udp_port_demux : routes one UDP frame at a time to one of four      |
// |                       channels by destination port; unmatched are eaten. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module turf_udp_port_demux #(
  parameter logic [15:0] PORT0 = 16'd21603,
  parameter logic [15:0] PORT1 = 16'd21604,
  parameter logic [15:0] PORT2 = 16'd21605,
  parameter logic [15:0] PORT3 = 16'd21606
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_udphdr_tdata,
  input  logic [15:0] s_udphdr_tdest,
  input  logic        s_udphdr_tvalid,
  output logic        s_udphdr_tready,
  input  logic [63:0] s_udpdata_tdata,
  input  logic [7:0]  s_udpdata_tkeep,
  input  logic        s_udpdata_tlast,
  input  logic        s_udpdata_tvalid,
  output logic        s_udpdata_tready,
  output logic [63:0] m_udphdr_tdata,
  output logic [3:0]  m_udphdr_tvalid,
  input  logic [3:0]  m_udphdr_tready,
  output logic [63:0] m_udpdata_tdata,
  output logic [7:0]  m_udpdata_tkeep,
  output logic        m_udpdata_tlast,
  output logic [3:0]  m_udpdata_tvalid,
  input  logic [3:0]  m_udpdata_tready,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  sel;
  logic [63:0] hdr_q;
  logic [15:0] drop_cnt;

  logic        hit;
  logic [1:0]  hit_idx;
  logic        hdr_fire;
  logic        data_fire;
  logic [3:0]  sel_onehot;

  // Priority chain: the lowest-numbered port wins when parameters collide.
  always_comb begin
    hit     = 1'b1;
    hit_idx = 2'd0;
    if (s_udphdr_tdest == PORT0)      hit_idx = 2'd0;
    else if (s_udphdr_tdest == PORT1) hit_idx = 2'd1;
    else if (s_udphdr_tdest == PORT2) hit_idx = 2'd2;
    else if (s_udphdr_tdest == PORT3) hit_idx = 2'd3;
    else                              hit     = 1'b0;
  end

  assign hdr_fire   = s_udphdr_tvalid && s_udphdr_tready;
  assign data_fire  = s_udpdata_tvalid && s_udpdata_tready;
  assign sel_onehot = 4'b0001 << sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 2'd0;
      hdr_q    <= 64'd0;
      drop_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hdr_fire) begin
            hdr_q <= s_udphdr_tdata;
            if (hit) begin
              sel   <= hit_idx;
              state <= HDR;
            end else begin
              state <= DROP;
            end
          end
        end
        HDR: begin
          if (m_udphdr_tready[sel]) state <= DATA;
        end
        DATA: begin
          if (data_fire && s_udpdata_tlast) state <= IDLE;
        end
        DROP: begin
          if (data_fire && s_udpdata_tlast) begin
            state <= IDLE;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are held low throughout reset, whatever the state.
  always_comb begin
    s_udphdr_tready  = 1'b0;
    s_udpdata_tready = 1'b0;
    m_udphdr_tvalid  = 4'd0;
    m_udpdata_tvalid = 4'd0;
    if (!rst) begin
      case (state)
        IDLE: s_udphdr_tready = 1'b1;
        HDR:  m_udphdr_tvalid = sel_onehot;
        DATA: begin
          s_udpdata_tready = m_udpdata_tready[sel];
          m_udpdata_tvalid = s_udpdata_tvalid ? sel_onehot : 4'd0;
        end
        DROP: s_udpdata_tready = 1'b1;
        default: s_udphdr_tready = 1'b0;
      endcase
    end
  end

  assign m_udphdr_tdata  = hdr_q;
  assign m_udpdata_tdata = s_udpdata_tdata;
  assign m_udpdata_tkeep = s_udpdata_tkeep;
  assign m_udpdata_tlast = s_udpdata_tlast;
  assign drop_count      = drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_turf_udp_port_demux.sv
`default_nettype none
// Bench for turf_udp_port_demux: directed frames checked against a
// frame-level reference model plus literal expectations.
module tb_turf_udp_port_demux;
  localparam logic [15:0] P0 = 16'd21603;
  localparam logic [15:0] P1 = 16'd21604;
  localparam logic [15:0] P2 = 16'd21605;
  localparam logic [15:0] P3 = 16'd21604;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_udphdr_tdata = '0;
  logic [15:0] s_udphdr_tdest = '0;
  logic        s_udphdr_tvalid = 1'b0;
  logic        s_udphdr_tready;
  logic [63:0] s_udpdata_tdata = '0;
  logic [7:0]  s_udpdata_tkeep = '0;
  logic        s_udpdata_tlast = 1'b0;
  logic        s_udpdata_tvalid = 1'b0;
  logic        s_udpdata_tready;
  logic [63:0] m_udphdr_tdata;
  logic [3:0]  m_udphdr_tvalid;
  logic [3:0]  m_udphdr_tready = 4'hF;
  logic [63:0] m_udpdata_tdata;
  logic [7:0]  m_udpdata_tkeep;
  logic        m_udpdata_tlast;
  logic [3:0]  m_udpdata_tvalid;
  logic [3:0]  m_udpdata_tready = 4'hF;
  logic [15:0] drop_count;

  turf_udp_port_demux #(.PORT0(P0), .PORT1(P1), .PORT2(P2), .PORT3(P3)) dut (
    .clk(clk), .rst(rst),
    .s_udphdr_tdata(s_udphdr_tdata), .s_udphdr_tdest(s_udphdr_tdest),
    .s_udphdr_tvalid(s_udphdr_tvalid), .s_udphdr_tready(s_udphdr_tready),
    .s_udpdata_tdata(s_udpdata_tdata), .s_udpdata_tkeep(s_udpdata_tkeep),
    .s_udpdata_tlast(s_udpdata_tlast), .s_udpdata_tvalid(s_udpdata_tvalid),
    .s_udpdata_tready(s_udpdata_tready),
    .m_udphdr_tdata(m_udphdr_tdata), .m_udphdr_tvalid(m_udphdr_tvalid),
    .m_udphdr_tready(m_udphdr_tready),
    .m_udpdata_tdata(m_udpdata_tdata), .m_udpdata_tkeep(m_udpdata_tkeep),
    .m_udpdata_tlast(m_udpdata_tlast), .m_udpdata_tvalid(m_udpdata_tvalid),
    .m_udpdata_tready(m_udpdata_tready),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  function automatic int lookup(input logic [15:0] d);
    logic [15:0] tab [4];
    tab = '{P0, P1, P2, P3};
    for (int i = 0; i < 4; i++) if (d == tab[i]) return i;
    return -1;
  endfunction

  bit          in_frame = 1'b0;
  bit          hdr_owed = 1'b0;
  int          ch = 0;
  logic [63:0] m_hdr = '0;
  int          m_cnt = 0;
  bit          preload_go = 1'b0;
  bit          preload_done = 1'b0;
  bit          mdl_sready;

  always @(posedge clk) begin
    if (preload_go && !preload_done) begin
      m_cnt = 32'hFFFE;
      preload_done = 1'b1;
    end
    if (rst) begin
      in_frame = 1'b0;
      hdr_owed = 1'b0;
      m_hdr    = '0;
      m_cnt    = 0;
    end else if (!in_frame) begin
      if (s_udphdr_tvalid) begin
        m_hdr    = s_udphdr_tdata;
        ch       = lookup(s_udphdr_tdest);
        in_frame = 1'b1;
        hdr_owed = (ch >= 0);
      end
    end else if (hdr_owed) begin
      if (m_udphdr_tready[ch]) hdr_owed = 1'b0;
    end else begin
      mdl_sready = (ch < 0) ? 1'b1 : m_udpdata_tready[ch];
      if (s_udpdata_tvalid && mdl_sready && s_udpdata_tlast) begin
        in_frame = 1'b0;
        if (ch < 0 && m_cnt < 65535) m_cnt++;
      end
    end
  end

  // ---------------- per-cycle compare + output capture ----------------
  logic        e_hr, e_sr, e_act;
  logic [3:0]  e_hv, e_dv;
  logic [15:0] e_cnt;
  logic [63:0] out_q [$];
  bit          last_q [$];

  always @(negedge clk) begin
    e_hr  = !rst && !in_frame;
    e_hv  = (!rst && in_frame && hdr_owed) ? 4'(1 << ch) : 4'd0;
    e_act = !rst && in_frame && !hdr_owed;
    e_sr  = e_act && ((ch < 0) ? 1'b1 : m_udpdata_tready[ch]);
    e_dv  = (e_act && ch >= 0 && s_udpdata_tvalid) ? 4'(1 << ch) : 4'd0;
    e_cnt = (preload_go && !preload_done) ? 16'hFFFE : 16'(m_cnt);
    chk("s_udphdr_tready", s_udphdr_tready, e_hr);
    chk("m_udphdr_tvalid", m_udphdr_tvalid, e_hv);
    chk("s_udpdata_tready", s_udpdata_tready, e_sr);
    chk("m_udpdata_tvalid", m_udpdata_tvalid, e_dv);
    chk("drop_count", drop_count, e_cnt);
    if (e_hv != 4'd0) chk("m_udphdr_tdata", m_udphdr_tdata, m_hdr);
    if (e_dv != 4'd0) begin
      chk("m_udpdata_tdata", m_udpdata_tdata, s_udpdata_tdata);
      chk("m_udpdata_tkeep", m_udpdata_tkeep, s_udpdata_tkeep);
      chk("m_udpdata_tlast", m_udpdata_tlast, s_udpdata_tlast);
    end
    if (|(m_udpdata_tvalid & m_udpdata_tready)) begin
      out_q.push_back(m_udpdata_tdata);
      last_q.push_back(m_udpdata_tlast);
    end
  end

  // ---------------- stimulus ----------------
  bit         tog_en = 1'b0;
  logic [3:0] tog_pat = 4'b1001;  // bit k is ready[0] on data cycle k: 1,0,0,1
  int         tog_k = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [15:0] dest, input logic [63:0] d);
    bit done;
    done = 1'b0;
    s_udphdr_tdata  = d;
    s_udphdr_tdest  = dest;
    s_udphdr_tvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = s_udphdr_tready;
      tick();
    end
    s_udphdr_tvalid = 1'b0;
    chk("hdr_accept", done, 1'b1);
  endtask

  task automatic send_data(input int n, input logic [63:0] base, input bit with_last);
    bit done;
    for (int b = 0; b < n; b++) begin
      done = 1'b0;
      s_udpdata_tdata  = base + 64'(b);
      s_udpdata_tkeep  = (b == n - 1) ? 8'h0F : 8'hFF;
      s_udpdata_tlast  = with_last && (b == n - 1);
      s_udpdata_tvalid = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
        if (tog_en) m_udpdata_tready[0] = tog_pat[tog_k % 4];
        tog_k++;
        @(negedge clk);
        done = s_udpdata_tready;
        tick();
      end
      chk("beat_accept", done, 1'b1);
    end
    s_udpdata_tvalid = 1'b0;
    s_udpdata_tlast  = 1'b0;
  endtask

  task automatic check_beats(input string name, input int start, input int n, input logic [63:0] base);
    chk({name, "_count"}, 64'(out_q.size() - start), 64'(n));
    if (out_q.size() - start == n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, "_data"}, out_q[start + i], base + 64'(i));
        chk({name, "_last"}, 64'(last_q[start + i]), 64'(i == n - 1));
      end
    end
  endtask

  int start;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hdr_tready", s_udphdr_tready, 1'b0);
    chk("rst_drop_count", drop_count, 16'd0);
    chk("rst_hdr_tdata", m_udphdr_tdata, 64'd0);
    chk("rst_valids", {m_udphdr_tvalid, m_udpdata_tvalid, s_udpdata_tready}, 9'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hdr_tready", s_udphdr_tready, 1'b1);
    tick();

    // tdest 21605 -> channel 2, 3 beats
    send_hdr(16'd21605, 64'hC0A8_0001_1234_0018);
    @(negedge clk);
    chk("s1_hdr_valid", m_udphdr_tvalid, 4'b0100);
    chk("s1_hdr_tdata", m_udphdr_tdata, 64'hC0A8_0001_1234_0018);
    tick();
    start = out_q.size();
    send_data(3, 64'hA000, 1'b1);
    check_beats("s1", start, 3, 64'hA000);
    chk("s1_drop_count", drop_count, 16'd0);

    // Colliding PORT1/PORT3: 21604 goes to channel 1 only
    send_hdr(16'd21604, 64'h0A00_0002_5555_0010);
    @(negedge clk);
    chk("s4_hdr_valid", m_udphdr_tvalid, 4'b0010);
    tick();
    start = out_q.size();
    send_data(2, 64'hB000, 1'b1);
    check_beats("s4", start, 2, 64'hB000);

    // Channel 0 with downstream ready toggling
    send_hdr(16'd21603, 64'h0A00_0003_6666_0020);
    @(negedge clk);
    chk("s3_hdr_valid", m_udphdr_tvalid, 4'b0001);
    tick();
    tog_en = 1'b1;
    tog_k  = 0;
    start  = out_q.size();
    send_data(4, 64'hC000, 1'b1);
    tog_en = 1'b0;
    m_udpdata_tready = 4'hF;
    check_beats("s3", start, 4, 64'hC000);

    // Reset during beat 2 of 4
    send_hdr(16'd21605, 64'h0A00_0004_7777_0020);
    tick();
    send_data(1, 64'hD000, 1'b0);
    s_udpdata_tdata  = 64'hD001;
    s_udpdata_tkeep  = 8'hFF;
    s_udpdata_tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("s5_in_rst_valid", m_udpdata_tvalid, 4'd0);
    chk("s5_in_rst_ready", s_udpdata_tready, 1'b0);
    tick();
    rst = 1'b0;
    s_udpdata_tvalid = 1'b0;
    @(negedge clk);
    chk("s5_post_valid", {m_udphdr_tvalid, m_udpdata_tvalid}, 8'd0);
    chk("s5_post_idle", s_udphdr_tready, 1'b1);
    chk("s5_drop_count", drop_count, 16'd0);
    tick();
    send_hdr(16'd21603, 64'h0A00_0005_8888_0010);
    @(negedge clk);
    chk("s5_next_hdr_valid", m_udphdr_tvalid, 4'b0001);
    tick();
    start = out_q.size();
    send_data(2, 64'hE000, 1'b1);
    check_beats("s5", start, 2, 64'hE000);

    // Unmatched port 80: 5 beats swallowed
    start = out_q.size();
    send_hdr(16'd80, 64'h0A00_0006_9999_0028);
    send_data(5, 64'hF000, 1'b1);
    @(negedge clk);
    chk("s2_no_output", 64'(out_q.size() - start), 64'd0);
    chk("s2_next_hdr_ready", s_udphdr_tready, 1'b1);
    chk("s2_drop_count", drop_count, 16'd1);
    tick();

    // Saturation from a preloaded 16'hFFFE
    force dut.drop_cnt = 16'hFFFE;
    preload_go = 1'b1;
    tick();
    release dut.drop_cnt;
    @(negedge clk);
    chk("s6_preload", drop_count, 16'hFFFE);
    tick();
    for (int f = 0; f < 3; f++) begin
      send_hdr(16'd21606, 64'h0A00_0007_0000_0010 + 64'(f));
      send_data(2, 64'h1000 + 64'(f * 16), 1'b1);
      @(negedge clk);
      chk("s6_sat", drop_count, 16'hFFFF);
      tick();
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
